// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Data-memory responder. It accepts one load/store request at a time,
// waits a fixed number of cycles, then presents a response until the
// consumer takes it. Storage is a byte-lane RAM that is not cleared by reset.
// Stores are written on the cycle the request is accepted. Loads read the
// RAM on the edge that enters RESP.
//
// Parameters
//   LATENCY      cycles from request acceptance to resp_valid (1..15)
//   DEPTH_WORDS  number of 32-bit words (power of two)
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   req_valid    request strobe
//   req_ready    high when a request can be accepted (IDLE only)
//   req_wen      1 = store, 0 = load
//   req_addr     byte address; bits above the word index are ignored
//   req_wdata    store data, right-justified for byte/half
//   req_size     00 byte, 01 half, 10 word, 11 illegal
//   req_sext     sign-extend a byte/half load
//   resp_valid   response available (RESP state)
//   resp_ready   consumer accepts the response
//   resp_rdata   load data (0 for stores and errors)
//   resp_err     misaligned access or illegal size
//   busy         high while a request is outstanding (ACCESS or RESP)
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int LATENCY     = 2,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_sext,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state_reg;
    logic [3:0]         cnt_reg;
    logic               lat_wen_reg;
    logic [IDX_W+1:0]   lat_addr_reg;
    logic [1:0]         lat_size_reg;
    logic               lat_sext_reg;
    logic               resp_valid_reg;
    logic [31:0]        resp_rdata_reg;
    logic               resp_err_reg;
    logic               busy_reg;
    logic               req_ready_reg;

    // Request fields come straight from the inputs while IDLE. Afterwards
    // they come from the copies latched at acceptance. This lets the
    // LATENCY=1 path capture load data on the acceptance edge itself.
    logic               sel_from_req;
    logic               sel_wen;
    logic [IDX_W+1:0]   sel_addr;
    logic [1:0]         sel_size;
    logic               sel_sext;
    logic               sel_err;
    logic [IDX_W-1:0]   sel_idx;
    logic               accept;
    logic [3:0]         lane_mask;
    logic [3:0]         wr_en;
    logic [31:0]        wr_data;
    logic [31:0]        rd_word;
    logic [7:0]         byte_val;
    logic [15:0]        half_val;
    logic [31:0]        load_data;

    // The address bits above the word index are intentionally ignored, so
    // accesses wrap around the memory size.
    logic               unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:IDX_W+2];

    always_comb begin
        sel_from_req = (state_reg == IDLE);
        sel_wen      = sel_from_req ? req_wen                : lat_wen_reg;
        sel_addr     = sel_from_req ? req_addr[IDX_W+1:0]    : lat_addr_reg;
        sel_size     = sel_from_req ? req_size               : lat_size_reg;
        sel_sext     = sel_from_req ? req_sext               : lat_sext_reg;
        sel_idx      = sel_addr[IDX_W+1:2];

        sel_err = 1'b0;
        case (sel_size)
            2'b00:   sel_err = 1'b0;
            2'b01:   sel_err = sel_addr[0];
            2'b10:   sel_err = (sel_addr[1:0] != 2'b00);
            default: sel_err = 1'b1;
        endcase

        accept = (state_reg == IDLE) && req_valid && req_ready_reg;

        // Little-endian lane selection.
        lane_mask = 4'b0000;
        wr_data   = req_wdata;
        case (sel_size)
            2'b00: begin
                lane_mask = 4'b0001 << sel_addr[1:0];
                wr_data   = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                lane_mask = sel_addr[1] ? 4'b1100 : 4'b0011;
                wr_data   = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                lane_mask = 4'b1111;
                wr_data   = req_wdata;
            end
            default: begin
                lane_mask = 4'b0000;
                wr_data   = req_wdata;
            end
        endcase
        wr_en = (accept && req_wen && !sel_err) ? lane_mask : 4'b0000;

        byte_val = rd_word[7:0];
        case (sel_addr[1:0])
            2'b00:   byte_val = rd_word[7:0];
            2'b01:   byte_val = rd_word[15:8];
            2'b10:   byte_val = rd_word[23:16];
            default: byte_val = rd_word[31:24];
        endcase
        half_val = sel_addr[1] ? rd_word[31:16] : rd_word[15:0];

        load_data = 32'h0;
        case (sel_size)
            2'b00:   load_data = {{24{sel_sext & byte_val[7]}}, byte_val};
            2'b01:   load_data = {{16{sel_sext & half_val[15]}}, half_val};
            2'b10:   load_data = rd_word;
            default: load_data = 32'h0;
        endcase
        if (sel_wen || sel_err) begin
            load_data = 32'h0;
        end
    end

    // One 8-bit RAM per byte lane. A lane is written only when its
    // byte-enable is set.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH_WORDS];

        always_ff @(posedge clk) begin
            if (wr_en[gi]) begin
                lane_mem[sel_idx] <= wr_data[8*gi +: 8];
            end
        end

        assign rd_word[8*gi +: 8] = lane_mem[sel_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= 32'h0;
            resp_err_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            req_ready_reg  <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        lat_wen_reg   <= req_wen;
                        lat_addr_reg  <= req_addr[IDX_W+1:0];
                        lat_size_reg  <= req_size;
                        lat_sext_reg  <= req_sext;
                        busy_reg      <= 1'b1;
                        req_ready_reg <= 1'b0;
                        if (LATENCY == 1) begin
                            state_reg      <= RESP;
                            cnt_reg        <= 4'd0;
                            resp_valid_reg <= 1'b1;
                            resp_rdata_reg <= load_data;
                            resp_err_reg   <= sel_err;
                        end else begin
                            state_reg <= ACCESS;
                            cnt_reg   <= 4'(LATENCY - 1);
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_reg <= 4'd1) begin
                        state_reg      <= RESP;
                        cnt_reg        <= 4'd0;
                        resp_valid_reg <= 1'b1;
                        resp_rdata_reg <= load_data;
                        resp_err_reg   <= sel_err;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                RESP: begin
                    // Moving back to IDLE takes this edge. A new request can
                    // only be accepted on the following edge.
                    if (resp_ready) begin
                        state_reg      <= IDLE;
                        resp_valid_reg <= 1'b0;
                        busy_reg       <= 1'b0;
                        req_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Directed bench for data_mem_responder (LATENCY=2, DEPTH_WORDS=1024).
// Inputs are driven on the falling edge, and outputs are sampled on the
// falling edge. Each transaction prints one line.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_sext;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    int tests_run;
    int tests_failed;

    data_mem_responder #(
        .LATENCY     (2),
        .DEPTH_WORDS (1024)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_size   (req_size),
        .req_sext   (req_sext),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Run one request/response pair with an expected latency of 2 edges. The
    // response is held for 'hold' extra cycles before resp_ready is raised.
    // Call this at a falling edge while the DUT is IDLE.
    task automatic xact(input string tag, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input logic sext,
                        input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_size  = size;
        req_sext  = sext;
        chk1({tag, " req_ready idle"}, req_ready, 1'b1);
        tick();
        // Scramble the request inputs. The latched fields must be used from here on.
        req_valid = 1'b0;
        req_wen   = ~wen;
        req_addr  = ~addr;
        req_wdata = 32'h5A5A5A5A;
        req_size  = ~size;
        req_sext  = ~sext;
        chk1({tag, " busy access"}, busy, 1'b1);
        chk1({tag, " resp_valid early"}, resp_valid, 1'b0);
        chk1({tag, " req_ready access"}, req_ready, 1'b0);
        tick();
        chk1({tag, " resp_valid"}, resp_valid, 1'b1);
        chk32({tag, " rdata"}, resp_rdata, exp_rdata);
        chk1({tag, " err"}, resp_err, exp_err);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk1({tag, " hold resp_valid"}, resp_valid, 1'b1);
            chk32({tag, " hold rdata"}, resp_rdata, exp_rdata);
            chk1({tag, " hold busy"}, busy, 1'b1);
            chk1({tag, " hold req_ready"}, req_ready, 1'b0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk1({tag, " resp_valid done"}, resp_valid, 1'b0);
        chk1({tag, " busy done"}, busy, 1'b0);
        chk1({tag, " req_ready done"}, req_ready, 1'b1);
        $display("[TB] %s wen=%0b addr=%h size=%0d sext=%0b rdata=%h err=%0b",
                 tag, wen, addr, size, sext, exp_rdata, exp_err);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst        = 1'b1;
        req_valid  = 1'b1;   // reset must win over a pending request
        req_wen    = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_size   = 2'b10;
        req_sext   = 1'b0;
        resp_ready = 1'b1;

        @(negedge clk);
        tick();
        tick();
        chk1("reset resp_valid", resp_valid, 1'b0);
        chk1("reset busy", busy, 1'b0);
        chk1("reset req_ready", req_ready, 1'b1);
        chk32("reset rdata", resp_rdata, 32'h0);
        chk1("reset err", resp_err, 1'b0);
        rst        = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        tick();
        $display("[TB] reset checked");

        // Word store, then load it back.
        xact("st_w_10", 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 1'b0, 0);
        xact("ld_w_10", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 0);

        // Byte store over a zero word, then sign/zero-extended loads.
        xact("st_w_10z", 1'b1, 32'h10, 32'h00000000, 2'b10, 1'b0, 32'h0, 1'b0, 0);
        xact("st_b_13", 1'b1, 32'h13, 32'h12345680, 2'b00, 1'b0, 32'h0, 1'b0, 0);
        xact("ld_b_13s", 1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 32'hFFFFFF80, 1'b0, 0);
        xact("ld_b_13u", 1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 32'h00000080, 1'b0, 0);
        xact("ld_w_10b", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h80000000, 1'b0, 0);

        // Misaligned and illegal accesses, including stores that must not write.
        xact("st_w_20", 1'b1, 32'h20, 32'h11223344, 2'b10, 1'b0, 32'h0, 1'b0, 0);
        xact("ld_h_21", 1'b0, 32'h21, 32'h0, 2'b01, 1'b0, 32'h0, 1'b1, 0);
        xact("ld_w_22", 1'b0, 32'h22, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 0);
        xact("st_h_21", 1'b1, 32'h21, 32'hFFFFFFFF, 2'b01, 1'b0, 32'h0, 1'b1, 0);
        xact("st_x_20", 1'b1, 32'h20, 32'hFFFFFFFF, 2'b11, 1'b0, 32'h0, 1'b1, 0);
        xact("ld_w_20", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h11223344, 1'b0, 0);
        xact("ld_b_20", 1'b0, 32'h20, 32'h0, 2'b00, 1'b1, 32'h00000044, 1'b0, 0);

        // Halfword lanes.
        xact("st_h_22", 1'b1, 32'h22, 32'h9999ABCD, 2'b01, 1'b0, 32'h0, 1'b0, 0);
        xact("ld_h_22s", 1'b0, 32'h22, 32'h0, 2'b01, 1'b1, 32'hFFFFABCD, 1'b0, 0);
        xact("ld_h_20u", 1'b0, 32'h20, 32'h0, 2'b01, 1'b0, 32'h00003344, 1'b0, 0);
        xact("ld_w_20b", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'hABCD3344, 1'b0, 0);

        // Backpressure: the response is held for 5 cycles.
        xact("ld_hold5", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h80000000, 1'b0, 5);

        // Address wrap-around at 1024 words.
        xact("st_w_1000", 1'b1, 32'h1000, 32'h12345678, 2'b10, 1'b0, 32'h0, 1'b0, 0);
        xact("ld_w_0000", 1'b0, 32'h0000, 32'h0, 2'b10, 1'b0, 32'h12345678, 1'b0, 0);

        // Reset in the cycle after accepting a load discards the response.
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_addr  = 32'h20;
        req_size  = 2'b10;
        req_sext  = 1'b0;
        tick();
        req_valid = 1'b0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        chk1("rst_mid busy", busy, 1'b0);
        chk1("rst_mid req_ready", req_ready, 1'b1);
        chk1("rst_mid resp_valid", resp_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("rst_mid no resp", resp_valid, 1'b0);
        end
        $display("[TB] reset during access checked");
        xact("ld_after_rst", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'hABCD3344, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to resp_valid; legal range 1..15.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit storage words; must be a power of two.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-005 SHALL have ports req_valid in 1, req_ready out 1, req_wen in 1 (1=store), req_addr in 32, req_wdata in 32, req_size in 2 (00 byte, 01 half, 10 word), and req_sext in 1 (sign-extend loads).
REQ-006 SHALL have ports resp_valid out 1, resp_ready in 1, resp_rdata out 32, resp_err out 1 (misaligned or illegal size), and busy out 1 (pipeline stall request).

Function
REQ-007 SHALL implement FSM states IDLE, ACCESS and RESP, with exactly one request outstanding.
REQ-008 In IDLE, req_ready=1; a request is accepted on an edge with req_valid=1 and req_ready=1, and the FSM then moves to ACCESS with counter=LATENCY-1.
REQ-009 With LATENCY=1, the FSM SHALL go from IDLE directly to RESP on acceptance, so resp_valid is high in the first cycle after the acceptance edge.
REQ-010 In ACCESS, req_ready=0 and the counter decrements each cycle; at counter=1 the next edge enters RESP, so resp_valid rises exactly LATENCY cycles after the acceptance edge.
REQ-011 In RESP, resp_valid=1 and resp_rdata/resp_err are held stable until an edge with resp_ready=1, which returns the FSM to IDLE; a new request SHALL NOT be accepted on that same edge.
REQ-012 busy SHALL be 1 in ACCESS and in RESP, and 0 in IDLE.
REQ-013 The word index SHALL be req_addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so accesses wrap around modulo the memory size.
REQ-014 Byte order SHALL be little-endian: byte lane = addr[1:0]; a halfword uses lanes addr[1]*2 and +1.
REQ-015 Misalignment SHALL be a half access with addr[0]=1 or a word access with addr[1:0]!=0; req_size=11 is illegal. In either case: no write is performed, resp_err=1, and resp_rdata=0.
REQ-016 A store SHALL commit to the array on the acceptance edge, writing only the addressed lanes from the low bits of req_wdata; the response for a store has resp_rdata=0 and resp_err=0.
REQ-017 A load SHALL capture the addressed data on the edge entering RESP; a byte or half is right-justified, upper bits are filled with the sign bit if the latched sext=1, else zeros.
REQ-018 The request fields (wen, addr, size, sext) SHALL be latched at acceptance; changes on the req_* inputs afterwards have no effect.
REQ-019 If resp_ready=1 already in the first RESP cycle, the response SHALL complete in that single cycle.

Reset
REQ-020 On an edge with rst=1: state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0, busy=0; req_ready is 1 from the next cycle.
REQ-021 Reset in ACCESS or RESP SHALL discard the pending response; a store already committed at acceptance remains in memory.
REQ-022 Memory array contents SHALL NOT be cleared by reset; reads of never-written words return undefined data.
REQ-023 rst SHALL take priority over a simultaneous req_valid or resp_ready.

Verification
REQ-024 Scenario: LATENCY=2; store word 0xDEADBEEF to 0x10, then load word from 0x10 -> resp_valid exactly 2 cycles after each acceptance; load returns 0xDEADBEEF, resp_err=0.
REQ-025 Scenario: store byte 0x80 to 0x13 over the word 0x00000000, then load byte from 0x13 with sext=1 -> 0xFFFFFF80; with sext=0 -> 0x00000080; load word from 0x10 -> 0x80000000.
REQ-026 Scenario: load half from 0x21 and load word from 0x22 -> resp_err=1, resp_rdata=0; a following load of 0x20 shows no memory change.
REQ-027 Scenario: hold resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_rdata and busy held for all 5 cycles, req_ready=0; the FSM reaches IDLE one edge after resp_ready=1.
REQ-028 Scenario: DEPTH_WORDS=1024; store 0x12345678 to 0x1000, then load from 0x0000 -> 0x12345678 (wrap-around).
REQ-029 Scenario: assert rst in the cycle after accepting a load -> resp_valid never asserts, busy=0 and req_ready=1 on the next cycle, and a new request is then accepted normally.
